// File: rtl/phy_rx_align.sv
// phy_rx_align: per-lane serial receiver with comma-based byte alignment.
// Each lane deserialises its bit stream MSB-first, hunts for COMMA on every
// bit, confirms alignment with SYNC_COMMAS byte-spaced commas, then packs
// non-comma bytes into WORD_W-bit words. Lanes are fully independent.
module phy_rx_align #(
  parameter int         LANES          = 2,
  parameter int         WORD_W         = 32,
  parameter logic [7:0] COMMA          = 8'hBC,
  parameter int         SYNC_COMMAS    = 4,
  parameter int         MAX_DATA_BYTES = 16
) (
  input  logic                      clk_32f,
  input  logic                      reset,
  input  logic [LANES-1:0]          data_in,
  output logic [LANES*WORD_W-1:0]   data_out,
  output logic [LANES-1:0]          valid_out,
  output logic [LANES-1:0]          active
);

  localparam int         NBYTES  = WORD_W / 8;
  localparam logic [3:0] SYNC_C  = SYNC_COMMAS[3:0];
  localparam logic [7:0] MAX_C   = MAX_DATA_BYTES[7:0];
  localparam logic [3:0] LAST_BI = 4'(NBYTES - 1);

  typedef enum logic [1:0] {
    LOSS   = 2'd0,
    ALIGN  = 2'd1,
    SYNCED = 2'd2
  } state_e;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      state_e            st_q, st_d;
      logic [7:0]        sr_q, sr_d;
      logic [2:0]        bc_q, bc_d;
      logic [3:0]        cc_q, cc_d;
      logic [7:0]        dc_q, dc_d;
      logic [3:0]        bi_q, bi_d;
      logic [WORD_W-1:0] acc_q, acc_d;
      logic [WORD_W-1:0] dout_q, dout_d;
      logic              vld_q, vld_d;
      logic [7:0]        nxt;
      logic              is_comma;
      logic              boundary;

      // Candidate byte including the bit arriving on this edge.
      assign nxt      = {sr_q[6:0], data_in[gi]};
      assign is_comma = (nxt == COMMA);
      assign boundary = (bc_q == 3'd7);

      // State register: all lane state, cleared asynchronously by reset.
      always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
          st_q   <= LOSS;
          sr_q   <= '0;
          bc_q   <= '0;
          cc_q   <= '0;
          dc_q   <= '0;
          bi_q   <= '0;
          acc_q  <= '0;
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          st_q   <= st_d;
          sr_q   <= sr_d;
          bc_q   <= bc_d;
          cc_q   <= cc_d;
          dc_q   <= dc_d;
          bi_q   <= bi_d;
          acc_q  <= acc_d;
          dout_q <= dout_d;
          vld_q  <= vld_d;
        end
      end

      // Next-state logic: hunt, confirm alignment, drop on bad byte or long data run.
      always_comb begin
        st_d = st_q;
        case (st_q)
          LOSS: begin
            if (is_comma) st_d = (SYNC_COMMAS == 1) ? SYNCED : ALIGN;
          end
          ALIGN: begin
            if (boundary) begin
              if (!is_comma)                       st_d = LOSS;
              else if ((cc_q + 4'd1) == SYNC_C)    st_d = SYNCED;
            end
          end
          SYNCED: begin
            if (boundary && !is_comma && (dc_q == MAX_C)) st_d = LOSS;
          end
          default: st_d = LOSS;
        endcase
      end

      // Datapath/output logic: counters, byte packing and word strobe.
      always_comb begin
        sr_d   = nxt;
        bc_d   = bc_q + 3'd1;
        cc_d   = cc_q;
        dc_d   = dc_q;
        bi_d   = bi_q;
        acc_d  = acc_q;
        dout_d = dout_q;
        vld_d  = 1'b0;
        case (st_q)
          LOSS: begin
            // Bit counter restarts so the comma just seen marks byte phase 0.
            bc_d = 3'd0;
            if (is_comma) begin
              cc_d = 4'd1;
              dc_d = '0;
              bi_d = '0;
            end
          end
          ALIGN: begin
            if (boundary) begin
              if (is_comma) begin
                cc_d = cc_q + 4'd1;
                if ((cc_q + 4'd1) == SYNC_C) begin
                  dc_d = '0;
                  bi_d = '0;
                end
              end else begin
                cc_d = '0;
              end
            end
          end
          SYNCED: begin
            if (boundary) begin
              if (is_comma) begin
                dc_d = '0;
              end else if (dc_q == MAX_C) begin
                // Run too long: abandon the partial word without a strobe.
                dc_d = '0;
                bi_d = '0;
                cc_d = '0;
              end else begin
                dc_d = dc_q + 8'd1;
                for (int j = 0; j < NBYTES; j++) begin
                  if (bi_q == 4'(j)) acc_d[(NBYTES-1-j)*8 +: 8] = nxt;
                end
                if (bi_q == LAST_BI) begin
                  dout_d = acc_d;
                  vld_d  = 1'b1;
                  bi_d   = '0;
                end else begin
                  bi_d = bi_q + 4'd1;
                end
              end
            end
          end
          default: begin
            cc_d = '0;
          end
        endcase
      end

      assign data_out[gi*WORD_W +: WORD_W] = dout_q;
      assign valid_out[gi]                 = vld_q;
      assign active[gi]                    = (st_q == SYNCED);
    end
  endgenerate

endmodule

// File: tb/tb_phy_rx_align.sv
// tb_phy_rx_align: directed scenarios plus randomized streams, checked every
// cycle against a bit-level behavioural model of the receiver.
module tb_phy_rx_align;
  localparam int         LANES  = 2;
  localparam int         WORD_W = 32;
  localparam logic [7:0] COMMA  = 8'hBC;
  localparam int         SYNC   = 4;
  localparam int         MAXB   = 16;
  localparam int         MAXLEN = 4096;

  logic                    clk_32f = 1'b0;
  logic                    reset;
  logic [LANES-1:0]        data_in;
  logic [LANES*WORD_W-1:0] data_out;
  logic [LANES-1:0]        valid_out;
  logic [LANES-1:0]        active;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  phy_rx_align #(
    .LANES(LANES), .WORD_W(WORD_W), .COMMA(COMMA),
    .SYNC_COMMAS(SYNC), .MAX_DATA_BYTES(MAXB)
  ) dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .active(active)
  );

  always #5 clk_32f = ~clk_32f;

  // ---------------- behavioural model ----------------
  // mode: 0 hunting for a comma on any bit, 1 counting byte-spaced commas,
  // 2 locked. Byte boundaries are every 8th bit after the anchoring comma.
  int          m_mode   [LANES];
  int          m_nb     [LANES];
  int          m_anchor [LANES];
  int          m_commas [LANES];
  int          m_run    [LANES];
  int          m_cnt    [LANES];
  logic [7:0]  m_win    [LANES];
  logic [63:0] m_word   [LANES];
  logic [WORD_W-1:0] e_data [LANES];
  logic        e_valid  [LANES];
  logic        e_active [LANES];

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) begin
      m_mode[l] = 0; m_nb[l] = 0; m_anchor[l] = 0; m_commas[l] = 0;
      m_run[l] = 0; m_cnt[l] = 0; m_win[l] = 8'h00; m_word[l] = '0;
      e_data[l] = '0; e_valid[l] = 1'b0; e_active[l] = 1'b0;
    end
  endtask

  task automatic model_step(input int l, input logic b);
    bit bnd;
    e_valid[l] = 1'b0;
    m_nb[l]    = m_nb[l] + 1;
    m_win[l]   = {m_win[l][6:0], b};
    bnd = (((m_nb[l] - m_anchor[l]) % 8) == 0);
    if (m_mode[l] == 0) begin
      if (m_win[l] == COMMA) begin
        m_anchor[l] = m_nb[l];
        m_commas[l] = 1;
        if (SYNC == 1) begin
          m_mode[l] = 2; m_run[l] = 0; m_cnt[l] = 0; m_word[l] = '0;
        end else begin
          m_mode[l] = 1;
        end
      end
    end else if (m_mode[l] == 1) begin
      if (bnd) begin
        if (m_win[l] == COMMA) begin
          m_commas[l] = m_commas[l] + 1;
          if (m_commas[l] == SYNC) begin
            m_mode[l] = 2; m_run[l] = 0; m_cnt[l] = 0; m_word[l] = '0;
          end
        end else begin
          m_mode[l] = 0; m_commas[l] = 0;
        end
      end
    end else begin
      if (bnd) begin
        if (m_win[l] == COMMA) begin
          m_run[l] = 0;
        end else if (m_run[l] + 1 > MAXB) begin
          m_mode[l] = 0; m_cnt[l] = 0; m_word[l] = '0; m_commas[l] = 0;
        end else begin
          m_run[l]  = m_run[l] + 1;
          m_word[l] = {m_word[l][55:0], m_win[l]};
          m_cnt[l]  = m_cnt[l] + 1;
          if (m_cnt[l] == WORD_W / 8) begin
            e_data[l]  = m_word[l][WORD_W-1:0];
            e_valid[l] = 1'b1;
            m_cnt[l]   = 0;
            m_word[l]  = '0;
          end
        end
      end
    end
    e_active[l] = (m_mode[l] == 2);
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk_32f) begin
    #1;
    if (cmp_en) begin
      for (int l = 0; l < LANES; l++) begin
        checks++;
        if (active[l] !== e_active[l] || valid_out[l] !== e_valid[l] ||
            data_out[l*WORD_W +: WORD_W] !== e_data[l]) begin
          errors++;
          $display("FAIL model lane%0d t=%0t: got act=%b vld=%b data=%h expected act=%b vld=%b data=%h",
                   l, $time, active[l], valid_out[l], data_out[l*WORD_W +: WORD_W],
                   e_active[l], e_valid[l], e_data[l]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus streams ----------------
  bit sbits [LANES][MAXLEN];
  int slen  [LANES];

  int rise  [LANES];
  int fall  [LANES];
  int vcnt  [LANES];
  int vpos  [LANES][32];
  logic [WORD_W-1:0] vword [LANES][32];
  bit prev_act [LANES];

  task automatic clear_streams();
    for (int l = 0; l < LANES; l++) slen[l] = 0;
  endtask

  task automatic push_bit(input int l, input bit b);
    if (slen[l] < MAXLEN) begin
      sbits[l][slen[l]] = b;
      slen[l] = slen[l] + 1;
    end
  endtask

  task automatic push_byte(input int l, input logic [7:0] v);
    for (int i = 7; i >= 0; i--) push_bit(l, v[i]);
  endtask

  task automatic push_all(input logic [7:0] v);
    for (int l = 0; l < LANES; l++) push_byte(l, v);
  endtask

  task automatic push_word_all(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) push_all(w[i*8 +: 8]);
  endtask

  // One bit per lane; starts and ends at a falling edge.
  task automatic step(input logic [LANES-1:0] v, input int k);
    data_in = v;
    @(posedge clk_32f);
    if (!reset) for (int l = 0; l < LANES; l++) model_step(l, v[l]);
    #1;
    for (int l = 0; l < LANES; l++) begin
      if (active[l] && !prev_act[l] && rise[l] < 0) rise[l] = k;
      if (!active[l] && prev_act[l] && fall[l] < 0) fall[l] = k;
      prev_act[l] = active[l];
      if (valid_out[l] && vcnt[l] < 32) begin
        vpos[l][vcnt[l]]  = k;
        vword[l][vcnt[l]] = data_out[l*WORD_W +: WORD_W];
        vcnt[l] = vcnt[l] + 1;
      end
    end
    @(negedge clk_32f);
  endtask

  task automatic run_streams();
    int n;
    logic [LANES-1:0] v;
    n = 0;
    for (int l = 0; l < LANES; l++) begin
      if (slen[l] > n) n = slen[l];
      rise[l] = -1; fall[l] = -1; vcnt[l] = 0; prev_act[l] = active[l];
    end
    for (int k = 1; k <= n; k++) begin
      for (int l = 0; l < LANES; l++) v[l] = (k - 1 < slen[l]) ? sbits[l][k-1] : 1'b0;
      step(v, k);
    end
    clear_streams();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    data_in = '0;
    model_reset();
    repeat (n) @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b0;
  endtask

  task automatic random_run(input int nbits);
    int r;
    for (int l = 0; l < LANES; l++) begin
      while (slen[l] < nbits) begin
        r = $urandom_range(0, 9);
        if (r < 5) push_byte(l, COMMA);
        else if (r < 8) push_byte(l, 8'($urandom_range(0, 255)));
        else if (r == 8) begin
          int nb = $urandom_range(1, 7);
          for (int i = 0; i < nb; i++) push_bit(l, 1'($urandom_range(0, 1)));
        end else begin
          for (int i = 0; i < 20; i++) push_byte(l, 8'($urandom_range(0, 187)));
        end
      end
    end
    run_streams();
  endtask

  initial begin
    reset   = 1'b1;
    data_in = '0;
    model_reset();
    clear_streams();
    cmp_en = 1'b1;
    @(negedge clk_32f);

    // 1: basic lock and first word
    do_reset(8);
    check("reset_active", 64'(active), 64'h0);
    check("reset_data", 64'(data_out), 64'h0);
    repeat (4) push_all(COMMA);
    push_word_all(32'h01020304);
    run_streams();
    check("t1_rise0", 64'(rise[0]), 64'd32);
    check("t1_rise1", 64'(rise[1]), 64'd32);
    check("t1_vcnt0", 64'(vcnt[0]), 64'd1);
    check("t1_vpos0", 64'(vpos[0][0]), 64'd64);
    check("t1_word0", 64'(vword[0][0]), 64'h01020304);
    check("t1_word1", 64'(vword[1][0]), 64'h01020304);

    // 2: misaligned prefix
    do_reset(2);
    for (int l = 0; l < LANES; l++) begin
      push_bit(l, 1'b1); push_bit(l, 1'b0); push_bit(l, 1'b1);
    end
    repeat (4) push_all(COMMA);
    push_word_all(32'h11223344);
    run_streams();
    check("t2_rise", 64'(rise[0]), 64'd35);
    check("t2_vpos", 64'(vpos[0][0]), 64'd67);
    check("t2_word", 64'(vword[0][0]), 64'h11223344);

    // 3: broken comma sequence, then a clean lock
    do_reset(2);
    repeat (3) push_all(COMMA);
    push_all(8'h55);
    repeat (4) push_all(COMMA);
    push_word_all(32'h01020304);
    run_streams();
    check("t3_rise", 64'(rise[0]), 64'd64);
    check("t3_vpos", 64'(vpos[0][0]), 64'd96);

    // 4: comma inside a word, then an over-long data run
    do_reset(2);
    repeat (4) push_all(COMMA);
    push_all(8'hAA); push_all(8'hBB); push_all(COMMA); push_all(8'hCC); push_all(8'hDD);
    push_all(COMMA);
    for (int i = 1; i <= 17; i++) push_all(8'(i));
    repeat (2) push_all(8'h00);
    run_streams();
    check("t4_rise", 64'(rise[0]), 64'd32);
    check("t4_vpos0", 64'(vpos[0][0]), 64'd72);
    check("t4_word0", 64'(vword[0][0]), 64'hAABBCCDD);
    check("t4_word1", 64'(vword[0][1]), 64'h01020304);
    check("t4_word4", 64'(vword[0][4]), 64'h0D0E0F10);
    check("t4_vcnt", 64'(vcnt[0]), 64'd5);
    check("t4_fall", 64'(fall[0]), 64'd216);

    // 5: asynchronous reset mid-word
    do_reset(2);
    repeat (4) push_all(COMMA);
    push_word_all(32'h01020304);
    push_all(8'h05); push_all(8'h06);
    run_streams();
    check("t5_pre_active", 64'(active), 64'h3);
    check("t5_pre_data0", 64'(data_out[WORD_W-1:0]), 64'h01020304);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t5_async_active", 64'(active), 64'h0);
    check("t5_async_valid", 64'(valid_out), 64'h0);
    check("t5_async_data", 64'(data_out), 64'h0);
    @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b0;
    push_all(8'h07); push_all(8'h08);
    repeat (4) push_all(COMMA);
    push_word_all(32'hA1A2A3A4);
    run_streams();
    check("t5_rise", 64'(rise[0]), 64'd48);
    check("t5_vcnt", 64'(vcnt[0]), 64'd1);
    check("t5_word", 64'(vword[0][0]), 64'hA1A2A3A4);

    // 6: lane 1 offset by 5 bits
    do_reset(2);
    for (int i = 0; i < 5; i++) push_bit(1, 1'b0);
    for (int l = 0; l < LANES; l++) begin
      repeat (4) push_byte(l, COMMA);
      push_byte(l, 8'h01); push_byte(l, 8'h02); push_byte(l, 8'h03); push_byte(l, 8'h04);
    end
    run_streams();
    check("t6_rise0", 64'(rise[0]), 64'd32);
    check("t6_rise1", 64'(rise[1]), 64'd37);
    check("t6_vpos0", 64'(vpos[0][0]), 64'd64);
    check("t6_vpos1", 64'(vpos[1][0]), 64'd69);
    check("t6_word1", 64'(vword[1][0]), 64'h01020304);

    // Randomized streams, checked cycle by cycle against the model
    for (int r = 0; r < 3; r++) begin
      do_reset(2);
      random_run(2000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/phy_rx_align.md
Name: phy_rx_align

Overview:
- Parametrised per-lane serial receiver and comma aligner. Successor to the fixed two-lane phy_rx.
- Each of LANES serial inputs is sampled at the bit clock and deserialised MSB-first into bytes. Byte alignment locks after SYNC_COMMAS consecutive aligned COMMA bytes.
- Once locked, non-comma bytes are packed into WORD_W-bit words, and each lane raises its own active flag.
- Sits between the serial link pins and the receive-side demux/FIFO path.

Parameters:
- LANES, 2, number of independent serial lanes.
- WORD_W, 32, output word width per lane; must be a multiple of 8, from 8 to 64.
- COMMA, 8'hBC, alignment/idle byte.
- SYNC_COMMAS, 4, consecutive aligned commas required to lock; range 1 to 15.
- MAX_DATA_BYTES, 16, consecutive non-comma bytes tolerated while locked before sync is dropped; range 1 to 255.

Ports:
- clk_32f  input  1  serial bit clock; all state on rising edge.
- reset  input  1  asynchronous, active-high.
- data_in  input  LANES  serial bit per lane; bit i = lane i.
- data_out  output  LANES*WORD_W  assembled words; lane i at [i*WORD_W +: WORD_W].
- valid_out  output  LANES  one-cycle strobe per lane; data_out slice is valid in that cycle.
- active  output  LANES  lane i is locked (in SYNCED state).

Behaviour:
- Lanes are fully independent. Each lane has:
  - 8-bit shift register sr
  - 3-bit bit counter bc
  - comma counter cc
  - data-byte run counter dc
  - byte index bi
  - word accumulator
  - FSM
- Reset (async, active-high): all per-lane state clears immediately.
  - sr, bc, cc, dc, bi, accumulator = 0; FSM = LOSS.
  - data_out = 0, valid_out = 0, active = 0.
  - Takes effect even mid-word or mid-lock; the partial word is discarded.
- Every edge: nxt = {sr[6:0], data_in[i]} and sr <= nxt. The first received bit becomes byte MSB.
- LOSS (active=0):
  - bc is not used.
  - If nxt == COMMA: go to ALIGN, set cc=1, bc=0.
  - If SYNC_COMMAS==1, go directly to SYNCED instead.
- Byte boundary in ALIGN and SYNCED: an edge where bc==7; the byte is nxt. bc increments every edge and wraps 7->0.
- ALIGN:
  - At a boundary, if byte==COMMA: cc++. When cc reaches SYNC_COMMAS, go to SYNCED, active=1, dc=0, bi=0.
  - At a boundary, if byte!=COMMA: go to LOSS, cc=0.
  - Misaligned commas are not re-checked until back in LOSS.
- SYNCED, at each boundary:
  - byte==COMMA: idle byte. Discarded; dc=0; accumulator and bi untouched.
  - byte!=COMMA, before the limit: dc++. Byte is stored at accumulator bits [WORD_W-1-8*bi -: 8]; bi++.
  - When bi reaches WORD_W/8: data_out slice <= full word, valid_out=1 for exactly that one cycle, bi=0.
  - dc would exceed MAX_DATA_BYTES: go to LOSS, active=0, bi=0. The byte and partial word are discarded; no valid strobe.
- Timing and latency:
  - active rises on the clock edge that samples the last bit of the SYNC_COMMAS-th comma.
  - valid_out and data_out update on the edge sampling the last bit of the word's final byte.
  - Latency: 0 cycles after the final bit edge, because outputs are registered on that edge.
- Hold and wrap rules:
  - data_out holds its last value between strobes.
  - The counters saturate/wrap only as specified; cc never exceeds SYNC_COMMAS.
- Lanes may lock at different times and bit offsets; there is no cross-lane deskew.

Test Plan:
1. Reset asserted for 8 cycles, then 4x 8'hBC followed by bytes 01,02,03,04 on both lanes.
   - active=2'b11 from the edge of bit 32.
   - valid_out=2'b11 for exactly one cycle at bit 64.
   - Each lane's data_out = 32'h01020304.
2. 3 prefix bits 101, then 4x BC, then data 11,22,33,44.
   - Lock occurs at bit 35.
   - Word 32'h11223344 is produced; the misaligned prefix is ignored.
3. 3x BC, then 8'h55.
   - active stays 0 and the FSM returns to LOSS.
   - A following 4x BC locks normally.
4. While locked, send AA,BB,BC,CC,DD.
   - One word 32'hAABBCCDD; the comma is discarded.
   - Then 17 consecutive non-comma bytes: active falls at byte 17, no strobe for the partial word, lane returns to LOSS.
5. Lane 0 locked with 2 bytes of a word accumulated; assert reset for 1 cycle.
   - All outputs go to 0 immediately (asynchronously).
   - After release, the lane needs a fresh 4x BC; no stale word appears.
6. LANES=2: lane 0 gets 4x BC + 01020304; lane 1 gets 5 bits of offset, then the same stream.
   - Independent active rise and valid_out strobes 5 cycles apart, with correct words on each lane.
